image_filter_ctrl: RTL and testbench

// Frame sequencer in front of the ImageFilter pipeline (3x3/5x5 Gaussian -> Sobel -> gradient -> NMS).

---
 rtl/image_filter_pkg.sv | 31 +++
 rtl/image_filter_ctrl_beat_counter.sv | 42 ++++
 rtl/image_filter_ctrl.sv | 170 +++++++++++++++++
 tb/tb_image_filter_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/image_filter_pkg.sv
// Shared types for the ImageFilter frame sequencer: controller states and the
// frame configuration record, sized for the maximum supported frame.
package image_filter_pkg;

  localparam int MAX_ROWS = 2048;
  localparam int MAX_COLS = 2448;
  localparam int ROW_W    = $clog2(MAX_ROWS);
  localparam int COL_W    = $clog2(MAX_COLS);
  localparam int BEAT_W   = ROW_W + COL_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0]       bypass;
    logic             sel_5x5;
    logic [ROW_W-1:0] rows;
    logic [COL_W-1:0] cols;
  } frame_cfg_t;

  // A frame with zero rows or zero columns can never complete.
  function automatic logic cfg_valid(input frame_cfg_t c);
    return (c.rows != '0) && (c.cols != '0);
  endfunction

endpackage

// File: rtl/image_filter_ctrl_beat_counter.sv
// 2-D column/row beat counter for the input side of the frame sequencer.
// Column wraps at bpr-1 and carries into the row; o_last marks the final beat.
module frame_beat_counter
  import image_filter_pkg::*;
#(
  parameter int ROW_BITS = ROW_W,
  parameter int COL_BITS = COL_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [COL_BITS-1:0] i_bpr,
  input  logic [ROW_BITS-1:0] i_rows,
  output logic                o_last
);

  logic [COL_BITS-1:0] r_col;
  logic [ROW_BITS-1:0] r_row;
  logic                w_col_wrap;

  assign w_col_wrap = (r_col == i_bpr - COL_BITS'(1));
  assign o_last     = w_col_wrap && (r_row == i_rows - ROW_BITS'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + ROW_BITS'(1);
      end else begin
        r_col <= r_col + COL_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/image_filter_ctrl.sv
// Frame sequencer in front of the ImageFilter pipeline. Optional drain
// watchdog is built only when FRAME_TIMEOUT_EN is defined.
module image_filter_ctrl
  import image_filter_pkg::*;
#(
  parameter int DWIDTH = 10,
  parameter int PIXCNT = 8,
  parameter int ROWS   = image_filter_pkg::MAX_ROWS,
  parameter int COLS   = image_filter_pkg::MAX_COLS
`ifdef FRAME_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     cfg_wr,
  input  logic [2:0]               cfg_bypass,
  input  logic                     cfg_5x5_sel,
  input  logic [$clog2(ROWS)-1:0]  cfg_rows,
  input  logic [$clog2(COLS)-1:0]  cfg_cols,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DWIDTH*PIXCNT-1:0] src_data,
  input  logic                     src_vld,
  output logic                     src_rdy,
  output logic [DWIDTH*PIXCNT-1:0] filt_data,
  output logic                     filt_vld,
  output logic                     filt_new_frame,
  output logic [2:0]               filt_bypass,
  output logic                     filt_5x5_sel,
  output logic [$clog2(ROWS)-1:0]  filt_rows,
  output logic [$clog2(COLS)-1:0]  filt_cols,
  input  logic                     filt_out_vld,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     aborted,
  output logic                     cfg_err,
  output logic                     timeout_err,
  output logic [2:0]               dbg_state
);

  localparam int PIX_SH = $clog2(PIXCNT);
  localparam int PAD_W  = COL_W + 1;

  ctrl_state_t              r_state;
  frame_cfg_t               r_shadow, r_active, w_cfg_in, w_shadow_nxt;
  logic [BEAT_W-1:0]        r_out_cnt, w_total;
  logic [PAD_W-1:0]         w_cols_pad;
  logic [COL_W-1:0]         w_bpr;
  logic [DWIDTH*PIXCNT-1:0] r_filt_data;
  logic                     r_filt_vld, r_aborted, r_cfg_err;
  logic                     w_accept, w_last;

  // A same-cycle cfg_wr is visible to the start decision through w_shadow_nxt.
  assign w_cfg_in     = '{bypass: cfg_bypass, sel_5x5: cfg_5x5_sel, rows: cfg_rows, cols: cfg_cols};
  assign w_shadow_nxt = cfg_wr ? w_cfg_in : r_shadow;

  assign w_cols_pad = {1'b0, r_active.cols} + PAD_W'(PIXCNT - 1);
  assign w_bpr      = COL_W'(w_cols_pad >> PIX_SH);
  assign w_total    = BEAT_W'(r_active.rows) * BEAT_W'(w_bpr);

  // Upstream handshake: a beat transfers on a cycle where src_vld and src_rdy
  // are both high; src_rdy is high only in STREAM and never in an abort cycle.
  assign src_rdy  = (r_state == STREAM) && !abort;
  assign w_accept = src_vld && src_rdy;

  frame_beat_counter #(.ROW_BITS(ROW_W), .COL_BITS(COL_W)) u_in_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (r_state == START),
    .i_en    (w_accept),
    .i_bpr   (w_bpr),
    .i_rows  (r_active.rows),
    .o_last  (w_last)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_timeout_err;
  logic            w_wd_fire;

  assign w_wd_fire = !filt_out_vld && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                              r_wd <= '0;
    else if (r_state != DRAIN || filt_out_vld)   r_wd <= '0;
    else                                         r_wd <= r_wd + WD_W'(1);
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_active    <= '0;
      r_out_cnt   <= '0;
      r_filt_data <= '0;
      r_filt_vld  <= 1'b0;
      r_aborted   <= 1'b0;
      r_cfg_err   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_aborted  <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_filt_vld <= w_accept;
`ifdef FRAME_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      if (w_accept) r_filt_data <= src_data;
      if (cfg_wr)   r_shadow    <= w_cfg_in;

      if (r_state == START)
        r_out_cnt <= '0;
      else if (filt_out_vld && (r_state == STREAM || r_state == DRAIN))
        r_out_cnt <= r_out_cnt + BEAT_W'(1);

      if (abort && r_state != IDLE) begin
        r_state   <= IDLE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              if (cfg_valid(w_shadow_nxt)) begin
                r_active <= w_shadow_nxt;
                r_state  <= START;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          START:  r_state <= STREAM;
          STREAM: if (w_accept && w_last) r_state <= DRAIN;
          DRAIN: begin
            if (r_out_cnt == w_total) r_state <= DONE;
`ifdef FRAME_TIMEOUT_EN
            else if (w_wd_fire) begin
              r_state       <= DONE;
              r_timeout_err <= 1'b1;
            end
`endif
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign filt_data      = r_filt_data;
  assign filt_vld       = r_filt_vld;
  assign filt_new_frame = (r_state == START);
  assign frame_done     = (r_state == DONE);
  assign busy           = (r_state != IDLE);
  assign aborted        = r_aborted;
  assign cfg_err        = r_cfg_err;
  assign filt_bypass    = r_active.bypass;
  assign filt_5x5_sel   = r_active.sel_5x5;
  assign filt_rows      = r_active.rows;
  assign filt_cols      = r_active.cols;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_image_filter_ctrl.sv
// Randomised frame-level bench for image_filter_ctrl: a shadow/active config
// model, beat totals from rows*ceil(cols/PIXCNT) and a data scoreboard.
module tb_image_filter_ctrl;
  import image_filter_pkg::*;

  localparam int DWIDTH = 10;
  localparam int PIXCNT = 8;
  localparam int PW     = DWIDTH * PIXCNT;
  localparam int RW     = 11;
  localparam int CW     = 12;
  localparam int TO_CYC = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic [2:0]    cfg_bypass = '0;
  logic          cfg_5x5_sel = 1'b0;
  logic [RW-1:0] cfg_rows = '0;
  logic [CW-1:0] cfg_cols = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] src_data = '0;
  logic          src_vld = 1'b0;
  logic          filt_out_vld = 1'b0;
  logic          src_rdy, filt_vld, filt_new_frame, filt_5x5_sel;
  logic [PW-1:0] filt_data;
  logic [2:0]    filt_bypass, dbg_state;
  logic [RW-1:0] filt_rows;
  logic [CW-1:0] filt_cols;
  logic          busy, frame_done, aborted, cfg_err, timeout_err;

  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  logic [2:0]    m_sh_byp, m_act_byp;
  logic          m_sh_sel, m_act_sel;
  logic [RW-1:0] m_sh_rows, m_act_rows;
  logic [CW-1:0] m_sh_cols, m_act_cols;

  image_filter_ctrl #(
    .DWIDTH(DWIDTH), .PIXCNT(PIXCNT)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_wr(cfg_wr), .cfg_bypass(cfg_bypass),
    .cfg_5x5_sel(cfg_5x5_sel), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .start(start),
    .abort(abort), .src_data(src_data), .src_vld(src_vld), .src_rdy(src_rdy),
    .filt_data(filt_data), .filt_vld(filt_vld), .filt_new_frame(filt_new_frame),
    .filt_bypass(filt_bypass), .filt_5x5_sel(filt_5x5_sel), .filt_rows(filt_rows),
    .filt_cols(filt_cols), .filt_out_vld(filt_out_vld), .busy(busy), .frame_done(frame_done),
    .aborted(aborted), .cfg_err(cfg_err), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_act();
    chk("act_bypass", PW'(filt_bypass), PW'(m_act_byp));
    chk("act_5x5", PW'(filt_5x5_sel), PW'(m_act_sel));
    chk("act_rows", PW'(filt_rows), PW'(m_act_rows));
    chk("act_cols", PW'(filt_cols), PW'(m_act_cols));
  endtask

  task automatic drive_cfg(input logic [2:0] byp, input logic sel, input logic [RW-1:0] rows,
                           input logic [CW-1:0] cols);
    cfg_wr = 1'b1; cfg_bypass = byp; cfg_5x5_sel = sel; cfg_rows = rows; cfg_cols = cols;
    m_sh_byp = byp; m_sh_sel = sel; m_sh_rows = rows; m_sh_cols = cols;
  endtask

  // One frame: optional same-cycle cfg write, random src gaps, pipeline output
  // beats that never outrun emitted beats, optional abort or short output count.
  task automatic run_frame(input logic wr, input logic [2:0] byp, input logic sel,
                           input logic [RW-1:0] rows, input logic [CW-1:0] cols,
                           input int vld_pct, input int abort_after, input int out_short,
                           input logic mid_wr);
    int total, acc, outs, out_lim, emitted, cyc, last_out, last_acc, n;
    logic exp_vld;
    if (wr) drive_cfg(byp, sel, rows, cols);
    start = 1'b1;
    m_act_byp = m_sh_byp; m_act_sel = m_sh_sel; m_act_rows = m_sh_rows; m_act_cols = m_sh_cols;
    total   = int'(m_act_rows) * ((int'(m_act_cols) + PIXCNT - 1) / PIXCNT);
    out_lim = total - out_short;
    step();
    cfg_wr = 1'b0; start = 1'b0;
    chk("new_frame", PW'(filt_new_frame), PW'(1'b1));
    chk("busy_start", PW'(busy), PW'(1'b1));
    chk("rdy_start", PW'(src_rdy), PW'(1'b0));
    chk("dbg_start", PW'(dbg_state), PW'(START));
    check_act();
    step();
    chk("new_frame_1cyc", PW'(filt_new_frame), PW'(1'b0));
    acc = 0; outs = 0; emitted = 0; cyc = 0; last_out = 0; last_acc = 0; exp_vld = 1'b0;
    while (1) begin
      chk("filt_vld", PW'(filt_vld), PW'(exp_vld));
      if (exp_vld) begin
        chk("filt_data", filt_data, exp_q.pop_front());
        emitted++;
      end
      chk("no_early_done", PW'(frame_done), PW'(1'b0));
      chk("no_restart", PW'(filt_new_frame), PW'(1'b0));
      check_act();
      if (abort_after > 0 && acc == abort_after) begin
        abort = 1'b1; src_vld = 1'b0; filt_out_vld = 1'b0; cfg_wr = 1'b0; start = 1'b0;
        step();
        abort = 1'b0;
        chk("aborted", PW'(aborted), PW'(1'b1));
        chk("busy_abort", PW'(busy), PW'(1'b0));
        chk("rdy_after_abort", PW'(src_rdy), PW'(1'b0));
        chk("no_done_abort", PW'(frame_done), PW'(1'b0));
        step();
        chk("aborted_1cyc", PW'(aborted), PW'(1'b0));
        chk("no_done_abort2", PW'(frame_done), PW'(1'b0));
        exp_q.delete();
        return;
      end
      if (acc == total && emitted == total && outs == out_lim) break;
      if (cyc > 3000) begin
        chk("frame_budget", PW'(outs), PW'(out_lim));
        break;
      end
      chk("src_rdy", PW'(src_rdy), PW'(acc < total));
      src_vld  = ($urandom_range(99) < vld_pct);
      src_data = PW'({$urandom(), $urandom(), $urandom()});
      exp_vld  = src_vld && (acc < total);
      if (exp_vld) begin
        exp_q.push_back(src_data);
        acc++;
        last_acc = cyc;
      end
      filt_out_vld = (outs < emitted) && (outs < out_lim) && ($urandom_range(1) == 1);
      if (filt_out_vld) begin
        outs++;
        last_out = cyc;
      end
      start  = (cyc == 2);
      cfg_wr = 1'b0;
      if (mid_wr && cyc == 3) drive_cfg(3'b101, 1'b1, 2, 8);
      cyc++;
      step();
    end
    src_vld = 1'b0; filt_out_vld = 1'b0; cfg_wr = 1'b0; start = 1'b0;
    n = 0;
    while (!frame_done && n < TO_CYC + 8) begin
      chk("drain_vld", PW'(filt_vld), PW'(1'b0));
      step();
      cyc++;
      n++;
    end
    chk("frame_done", PW'(frame_done), PW'(1'b1));
    if (out_short > 0) begin
      chk("timeout_err", PW'(timeout_err), PW'(1'b1));
      chk("timeout_delay", PW'(cyc - ((last_out > last_acc) ? last_out : last_acc)), PW'(TO_CYC + 1));
    end else begin
      chk("no_timeout_err", PW'(timeout_err), PW'(1'b0));
    end
    step();
    chk("done_1cyc", PW'(frame_done), PW'(1'b0));
    chk("busy_idle", PW'(busy), PW'(1'b0));
  endtask

  initial begin
    m_sh_byp = '0; m_sh_sel = 1'b0; m_sh_rows = '0; m_sh_cols = '0;
    m_act_byp = '0; m_act_sel = 1'b0; m_act_rows = '0; m_act_cols = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_busy", PW'(busy), PW'(1'b0));
    chk("rst_src_rdy", PW'(src_rdy), PW'(1'b0));
    chk("rst_filt_vld", PW'(filt_vld), PW'(1'b0));
    chk("rst_filt_data", filt_data, PW'(0));
    chk("rst_new_frame", PW'(filt_new_frame), PW'(1'b0));
    chk("rst_done", PW'(frame_done), PW'(1'b0));
    chk("rst_aborted", PW'(aborted), PW'(1'b0));
    chk("rst_cfg_err", PW'(cfg_err), PW'(1'b0));
    chk("rst_timeout", PW'(timeout_err), PW'(1'b0));
    chk("rst_dbg", PW'(dbg_state), PW'(IDLE));
    check_act();
    sys_rst_n = 1'b1;
    step();

    // Full frame with back-to-back beats; then column count not a multiple of PIXCNT with gaps.
    run_frame(1'b1, 3'b000, 1'b0, 4, 32, 100, 0, 0, 1'b0);
    run_frame(1'b1, 3'b011, 1'b0, 2, 30, 55, 0, 0, 1'b0);

    // Shadow written mid-frame stays inactive until the next START.
    run_frame(1'b1, 3'b010, 1'b0, 3, 17, 80, 0, 0, 1'b1);
    run_frame(1'b0, 3'b000, 1'b0, 0, 0, 70, 0, 0, 1'b0);

    // Rejected starts: zero rows with same-cycle write, zero cols, then stale invalid shadow.
    drive_cfg(3'b001, 1'b1, 0, 16);
    start = 1'b1;
    step();
    cfg_wr = 1'b0; start = 1'b0;
    chk("cfg_err_rows", PW'(cfg_err), PW'(1'b1));
    chk("cfg_err_busy", PW'(busy), PW'(1'b0));
    chk("cfg_err_nf", PW'(filt_new_frame), PW'(1'b0));
    step();
    chk("cfg_err_1cyc", PW'(cfg_err), PW'(1'b0));
    drive_cfg(3'b001, 1'b1, 5, 0);
    step();
    cfg_wr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_cols", PW'(cfg_err), PW'(1'b1));
    chk("cfg_err_busy2", PW'(busy), PW'(1'b0));
    check_act();

    // abort in IDLE does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort", PW'(aborted), PW'(1'b0));
    chk("idle_abort_busy", PW'(busy), PW'(1'b0));

    // Abort after five beats, then a normal frame.
    run_frame(1'b1, 3'b110, 1'b1, 4, 32, 100, 5, 0, 1'b0);
    run_frame(1'b1, 3'b100, 1'b0, 1, 1, 90, 0, 0, 1'b0);

    for (int f = 0; f < 4; f++) begin
      run_frame(1'b1, 3'($urandom_range(7)), 1'($urandom_range(1)), RW'($urandom_range(1, 5)),
                CW'($urandom_range(1, 80)), $urandom_range(30, 100), 0, 0, 1'b0);
    end

`ifdef FRAME_TIMEOUT_EN
    run_frame(1'b1, 3'b000, 1'b0, 2, 64, 100, 0, 1, 1'b0);
    run_frame(1'b1, 3'b001, 1'b1, 2, 24, 75, 0, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
